// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              bin_q, bin_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic              bit_d;
  logic              bit_bout;
  logic              accept;

  // Single full-subtractor cell on the operand LSBs.
  assign bit_d    = a_q[0] ^ b_q[0] ^ bin_q;
  assign bit_bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    accept   = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = start;
      end
      StShift: begin
        res_d = {bit_d, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bin_d = bit_bout;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          diff_d   = {bit_d, res_q[WIDTH-1:1]};
          borrow_d = bit_bout;
`ifdef SERIAL_SUB_OVF_EN
          // On the last step the operand LSBs are the original sign bits.
          ovf_d    = (a_q[0] != b_q[0]) & (bit_d != a_q[0]);
`endif
        end
      end
      StDone: begin
        accept  = start;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = StShift;
      a_d     = a;
      b_d     = b;
      res_d   = '0;
      cnt_d   = '0;
      bin_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations checked
// against an arithmetic reference model; overflow checks follow SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int unsigned W = 4;
  localparam int unsigned Bound = 4 * W + 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain modular / signed arithmetic.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned r;
    r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
    return r[W-1:0];
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, sd;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    sd = sx - sy;
    return (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a one-cycle start; returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Edges until done is seen, bounded.
  task automatic wait_done(output int cycles, output bit seen);
    cycles = 0;
    while (!done && cycles < Bound) begin
      step();
      cycles++;
    end
    seen = done;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b, required 0 0", i, busy, done);
      end
    end
    checks++;
    if (diff !== '0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: diff=%h borrow=%b, required 0 0", diff, borrow);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b, required 0", overflow);
    end
`endif
  endtask

  // Cycle-exact check of busy/done/hold for directed vectors.
  task automatic test_directed();
    logic [W-1:0] va [6] = '{4'h9, 4'h3, 4'hF, 4'h7, 4'h5, 4'h0};
    logic [W-1:0] vb [6] = '{4'h3, 4'h9, 4'hF, 4'h8, 4'h2, 4'h1};
    logic [W-1:0] held;
    logic [W-1:0] ed;
    logic         eb;
    for (int v = 0; v < 6; v++) begin
      held = diff;
      ed   = ref_diff(va[v], vb[v]);
      eb   = ref_borrow(va[v], vb[v]);
      launch(va[v], vb[v]);
      for (int j = 0; j < W; j++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || diff !== held) begin
          errors++;
          $display("FAIL directed_busy %h-%h cycle %0d: busy=%b done=%b diff=%h, required 1 0 %h",
                   va[v], vb[v], j, busy, done, diff, held);
        end
        step();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || diff !== ed || borrow !== eb) begin
        errors++;
        $display("FAIL directed_done %h-%h: done=%b busy=%b diff=%h borrow=%b, required 1 0 %h %b",
                 va[v], vb[v], done, busy, diff, borrow, ed, eb);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (overflow !== ref_ovf(va[v], vb[v])) begin
        errors++;
        $display("FAIL directed_ovf %h-%h: got %b, required %b", va[v], vb[v], overflow,
                 ref_ovf(va[v], vb[v]));
      end
`endif
      step();
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== ed || borrow !== eb) begin
        errors++;
        $display("FAIL directed_hold %h-%h: done=%b busy=%b diff=%h borrow=%b, required 0 0 %h %b",
                 va[v], vb[v], done, busy, diff, borrow, ed, eb);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv;
    int           cyc;
    bit           seen;
    for (int n = 0; n < 40; n++) begin
      av = W'($urandom);
      bv = W'($urandom);
      launch(av, bv);
      wait_done(cyc, seen);
      checks++;
      if (!seen || cyc != W || diff !== ref_diff(av, bv) || borrow !== ref_borrow(av, bv)) begin
        errors++;
        $display("FAIL random %h-%h: seen=%0d after %0d diff=%h borrow=%b, required 1 %0d %h %b",
                 av, bv, seen, cyc, diff, borrow, W, ref_diff(av, bv), ref_borrow(av, bv));
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (overflow !== ref_ovf(av, bv)) begin
        errors++;
        $display("FAIL random_ovf %h-%h: got %b, required %b", av, bv, overflow, ref_ovf(av, bv));
      end
`endif
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic test_start_ignored();
    int           ndone = 0;
    logic [W-1:0] got_d = '0;
    logic         got_b = 1'b1;
    step();
    launch(4'h9, 4'h3);
    step();
    start = 1'b1;
    a     = 4'h1;
    b     = 4'h1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) begin
        ndone++;
        got_d = diff;
        got_b = borrow;
      end
      step();
    end
    checks++;
    if (ndone != 1 || got_d !== 4'h6 || got_b !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: dones=%0d diff=%h borrow=%b, required 1 6 0",
               ndone, got_d, got_b);
    end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2;
    bit seen1, seen2;
    launch(4'h9, 4'h3);
    wait_done(cyc1, seen1);
    checks++;
    if (!seen1 || diff !== 4'h6 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: seen=%0d diff=%h borrow=%b, required 1 6 0", seen1, diff, borrow);
    end
    launch(4'h2, 4'h5);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
    end
    wait_done(cyc2, seen2);
    checks++;
    if (!seen2 || cyc2 + 1 != W + 1 || diff !== 4'hD || borrow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: seen=%0d spacing=%0d diff=%h borrow=%b, required 1 %0d d 1",
               seen2, cyc2 + 1, diff, borrow, W + 1);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int  ndone = 0;
    int  cyc;
    bit  seen;
    step();
    launch(4'h9, 4'h3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b done=%b diff=%h borrow=%b, required 0 0 0 0",
               busy, done, diff, borrow);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL abort_overflow: got %b, required 0", overflow);
    end
`endif
    for (int i = 0; i < 2 * W; i++) begin
      if (done || busy) ndone++;
      step();
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL abort_no_done: active cycles=%0d, required 0", ndone);
    end
    launch(4'h2, 4'h5);
    wait_done(cyc, seen);
    checks++;
    if (!seen || cyc != W || diff !== 4'hD || borrow !== 1'b1) begin
      errors++;
      $display("FAIL abort_recover: seen=%0d after %0d diff=%h borrow=%b, required 1 %0d d 1",
               seen, cyc, diff, borrow, W);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Mutual-exclusion monitor on busy/done.
  always @(negedge clk) begin
    if (!rst && busy && done) begin
      errors++;
      $display("FAIL busy_done_overlap: busy=%b done=%b, required not both 1", busy, done);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
